qammod_sched: RTL and testbench

- Symbol scheduler that sits directly in front of qammod and sequences one frame at a time.
- Accepts a DATA_WIDTH-bit word stream over valid/ready.
- Emits a configurable preamble, then slices each word MSB-first into log2(MODULATION_ORDER)-bit symbols.
- Paces symbols to one per (cfg_period+1) clocks and drives the qammod symbol input and data-valid.

---
 rtl/qammod_pkg.sv | 18 +
 rtl/qammod_sched_if.sv | 31 +++
 rtl/qammod_sym_pacer.sv | 31 +++
 rtl/qammod_sched.sv | 150 +++++++++++++++
 tb/tb_qammod_sched.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/qammod_pkg.sv
// Shared state encoding and width helpers for the qammod symbol scheduler.
package qammod_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2
  } state_e;

  function automatic int sym_width(input int order);
    return $clog2(order);
  endfunction

  function automatic int syms_per_word(input int dw, input int order);
    return dw / $clog2(order);
  endfunction

endpackage

// File: rtl/qammod_sched_if.sv
// Control, payload stream and symbol output bundle between a frame source and qammod_sched.
interface qammod_sched_if #(
  parameter int SYM_W      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PERIOD_W   = 8,
  parameter int LEN_W      = 16
);
  logic                  start;
  logic                  abort;
  logic [LEN_W-1:0]      frame_len;
  logic [PERIOD_W-1:0]   cfg_period;
  logic [SYM_W-1:0]      cfg_preamble_sym;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [SYM_W-1:0]      sym;
  logic                  sym_dv;
  logic                  busy;
  logic                  done;
  logic                  underrun;

  modport master (
    output start, abort, frame_len, cfg_period, cfg_preamble_sym, s_data, s_valid,
    input  s_ready, sym, sym_dv, busy, done, underrun
  );

  modport slave (
    input  start, abort, frame_len, cfg_period, cfg_preamble_sym, s_data, s_valid,
    output s_ready, sym, sym_dv, busy, done, underrun
  );
endinterface

// File: rtl/qammod_sym_pacer.sv
// Symbol pacer: latches the period on clear, then ticks once every (period+1) running cycles.
// Tick is combinational from the counter; the counter holds while not running.
module qammod_sym_pacer #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_run,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                w_wrap;

  assign w_wrap = (r_cnt == r_period);
  assign o_tick = i_run && w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_period <= i_period;
      r_cnt    <= '0;
    end else if (i_run) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/qammod_sched.sv
// Frame scheduler ahead of qammod: preamble, then MSB-first word slicing at one symbol per period+1 clocks.
// Symbols appear one clock after their tick; s_ready only while the slice buffer is empty.
module qammod_sched
  import qammod_pkg::*;
#(
  parameter int MODULATION_ORDER = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int PREAMBLE_LEN     = 4,
  parameter int PERIOD_W         = 8,
  parameter int LEN_W            = 16
) (
  input logic           clk,
  input logic           rst,
  qammod_sched_if.slave bus
);
  localparam int SYM_W    = sym_width(MODULATION_ORDER);
  localparam int SPW      = syms_per_word(DATA_WIDTH, MODULATION_ORDER);
  localparam int SL_W     = $clog2(SPW + 1);
  localparam int PRE_W    = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;

  if (DATA_WIDTH % SYM_W != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of the symbol width");
  end

  state_e                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [SL_W-1:0]       r_sym_left;
  logic [LEN_W-1:0]      r_words_left;
  logic [PRE_W-1:0]      r_pre_cnt;
  logic [SYM_W-1:0]      r_pre_sym, r_sym, w_emit_sym;
  logic                  r_sym_dv, r_done, r_underrun;
  logic                  w_busy, w_tick, w_s_ready, w_accept;
  logic                  w_load, w_emit, w_under, w_fin;

  assign w_busy    = (r_state != IDLE);
  assign w_s_ready = (r_state == PAYLOAD) && (r_sym_left == '0) && (r_words_left != '0);
  assign w_accept  = bus.s_valid && w_s_ready;

  qammod_sym_pacer #(.PERIOD_W(PERIOD_W)) u_pacer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_load),
    .i_run    (w_busy),
    .i_period (bus.cfg_period),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_emit     = 1'b0;
    w_under    = 1'b0;
    w_fin      = 1'b0;
    w_emit_sym = r_shift[DATA_WIDTH-1 -: SYM_W];
    case (r_state)
      IDLE: begin
        if (bus.start && (bus.frame_len != '0)) begin
          w_load = 1'b1;
          w_next = (PREAMBLE_LEN == 0) ? PAYLOAD : PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (w_tick) begin
          w_emit     = 1'b1;
          w_emit_sym = r_pre_sym;
          if (r_pre_cnt == PRE_W'(PREAMBLE_LEN - 1)) w_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (w_tick) begin
          if (r_sym_left != '0) begin
            w_emit = 1'b1;
            w_fin  = (r_sym_left == SL_W'(1)) && (r_words_left == '0);
          end else if (w_accept) begin
            // Bypass keeps full rate when the buffer drains on a tick.
            w_emit     = 1'b1;
            w_emit_sym = bus.s_data[DATA_WIDTH-1 -: SYM_W];
            w_fin      = (SPW == 1) && (r_words_left == LEN_W'(1));
          end else begin
            w_under = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_fin) w_next = IDLE;
    if (bus.abort) begin
      w_next  = IDLE;
      w_load  = 1'b0;
      w_emit  = 1'b0;
      w_under = 1'b0;
      w_fin   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift      <= '0;
      r_sym_left   <= '0;
      r_words_left <= '0;
      r_pre_cnt    <= '0;
      r_pre_sym    <= '0;
      r_sym        <= '0;
      r_sym_dv     <= 1'b0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_sym_dv <= w_emit;
      r_done   <= w_fin;
      if (w_emit) r_sym <= w_emit_sym;
      if (w_under) r_underrun <= 1'b1;
      if (w_emit && (r_state == PREAMBLE)) r_pre_cnt <= r_pre_cnt + 1'b1;
      if (w_load) begin
        r_words_left <= bus.frame_len;
        r_pre_sym    <= bus.cfg_preamble_sym;
        r_pre_cnt    <= '0;
        r_sym_left   <= '0;
        r_underrun   <= 1'b0;
      end
      if (bus.abort) begin
        r_sym_left   <= '0;
        r_words_left <= '0;
      end else if (w_accept) begin
        r_words_left <= r_words_left - 1'b1;
        if (w_tick) begin
          r_shift    <= bus.s_data << SYM_W;
          r_sym_left <= SL_W'(SPW - 1);
        end else begin
          r_shift    <= bus.s_data;
          r_sym_left <= SL_W'(SPW);
        end
      end else if (w_emit && (r_state == PAYLOAD)) begin
        r_shift    <= r_shift << SYM_W;
        r_sym_left <= r_sym_left - 1'b1;
      end
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.sym      = r_sym;
  assign bus.sym_dv   = r_sym_dv;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.underrun = r_underrun;
endmodule

// File: tb/tb_qammod_sched.sv
// Directed bench for qammod_sched: hand-computed symbol/timing tables per frame scenario.
module tb_qammod_sched;
  logic clk = 1'b0;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  int         exp_off[$];
  logic [3:0] exp_sym[$];
  logic [7:0] words[$];

  qammod_sched_if #(.SYM_W(4), .DATA_WIDTH(8), .PERIOD_W(8), .LEN_W(16)) bus ();

  qammod_sched #(
    .MODULATION_ORDER (16),
    .DATA_WIDTH       (8),
    .PREAMBLE_LEN     (4),
    .PERIOD_W         (8),
    .LEN_W            (16)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tables();
    exp_off.delete();
    exp_sym.delete();
    words.delete();
  endtask

  task automatic add_exp(input int off, input logic [3:0] s);
    exp_off.push_back(off);
    exp_sym.push_back(s);
  endtask

  task automatic add_pre(input int first, input int step, input logic [3:0] s);
    for (int k = 0; k < 4; k++) add_exp(first + k * step, s);
  endtask

  // Offsets t count cycles after the start cycle (t=0); outputs sampled on the falling edge.
  task automatic run_frame(input string tag, input int period, input int len, input logic [3:0] psym,
                           input int hold_from, input int hold_to, input int abort_at,
                           input int restart_at, input int ncyc, input int exp_done,
                           input int exp_hs, input int exp_rdy, input logic exp_und);
    int idx = 0;
    int widx = 0;
    int hs = 0;
    int rdy = 0;
    int done_t = -1;
    @(negedge clk);
    bus.frame_len        = 16'(len);
    bus.cfg_period       = 8'(period);
    bus.cfg_preamble_sym = psym;
    bus.s_valid          = 1'b0;
    bus.start            = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      if (t == 1) chk({tag, "_busy_t1"}, 32'(bus.busy), 1);
      if (abort_at >= 0 && t == abort_at + 1) chk({tag, "_busy_after_abort"}, 32'(bus.busy), 0);
      if (bus.sym_dv) begin
        if (idx < exp_sym.size()) begin
          chk($sformatf("%s_sym%0d", tag, idx), 32'(bus.sym), 32'(exp_sym[idx]));
          chk($sformatf("%s_time%0d", tag, idx), 32'(t), 32'(exp_off[idx]));
        end else begin
          chk($sformatf("%s_extra_dv_t%0d", tag, t), 32'(idx), 32'(exp_sym.size()));
        end
        idx++;
      end
      if (bus.done) begin
        done_t = t;
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
      end
      bus.start   = (t == restart_at);
      bus.abort   = (t == abort_at);
      bus.s_valid = (widx < words.size()) && !(t >= hold_from && t < hold_to);
      bus.s_data  = (widx < words.size()) ? words[widx] : 8'h00;
      if (bus.s_ready) rdy++;
      if (bus.s_valid && bus.s_ready) begin
        hs++;
        widx++;
      end
    end
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    chk({tag, "_nsym"}, 32'(idx), 32'(exp_sym.size()));
    chk({tag, "_done_t"}, 32'(done_t), 32'(exp_done));
    chk({tag, "_handshakes"}, 32'(hs), 32'(exp_hs));
    chk({tag, "_ready_cycles"}, 32'(rdy), 32'(exp_rdy));
    chk({tag, "_underrun"}, 32'(bus.underrun), 32'(exp_und));
  endtask

  task automatic scen_basic(input string tag);
    clear_tables();
    words.push_back(8'h3C);
    words.push_back(8'h3C);
    add_pre(2, 1, 4'hA);
    add_exp(6, 4'h3);
    add_exp(7, 4'hC);
    run_frame(tag, 0, 1, 4'hA, -1, -1, -1, -1, 12, 7, 1, 1, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sym"}, 32'(bus.sym), 0);
    chk({tag, "_sym_dv"}, 32'(bus.sym_dv), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_underrun"}, 32'(bus.underrun), 0);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.start            = 1'b0;
    bus.abort            = 1'b0;
    bus.frame_len        = '0;
    bus.cfg_period       = '0;
    bus.cfg_preamble_sym = '0;
    bus.s_data           = '0;
    bus.s_valid          = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Zero-length start must be ignored.
    @(negedge clk);
    bus.frame_len = 16'd0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("len0_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("len0_dv", 32'(bus.sym_dv), 0);

    scen_basic("basic");

    // Pacing at period 3, with an ignored start while busy.
    clear_tables();
    words.push_back(8'h12);
    words.push_back(8'h34);
    add_pre(5, 4, 4'h5);
    add_exp(21, 4'h1);
    add_exp(25, 4'h2);
    add_exp(29, 4'h3);
    add_exp(33, 4'h4);
    run_frame("pace", 3, 2, 4'h5, -1, -1, -1, 6, 40, 33, 2, 2, 1'b0);

    // Underrun: payload withheld for the first three payload ticks.
    clear_tables();
    words.push_back(8'hF0);
    add_pre(2, 1, 4'h6);
    add_exp(9, 4'hF);
    add_exp(10, 4'h0);
    run_frame("under", 0, 1, 4'h6, 5, 8, -1, -1, 16, 10, 1, 4, 1'b1);

    // Backpressure at period 7 with a spare word always offered.
    clear_tables();
    words.push_back(8'h11);
    words.push_back(8'h22);
    words.push_back(8'h33);
    words.push_back(8'h44);
    add_pre(9, 8, 4'h9);
    add_exp(41, 4'h1);
    add_exp(49, 4'h1);
    add_exp(57, 4'h2);
    add_exp(65, 4'h2);
    add_exp(73, 4'h3);
    add_exp(81, 4'h3);
    run_frame("bp", 7, 3, 4'h9, -1, -1, -1, -1, 95, 81, 3, 3, 1'b0);

    // Abort after the third payload symbol of eight.
    clear_tables();
    words.push_back(8'h12);
    words.push_back(8'h34);
    words.push_back(8'h56);
    words.push_back(8'h78);
    add_pre(2, 1, 4'hA);
    add_exp(6, 4'h1);
    add_exp(7, 4'h2);
    add_exp(8, 4'h3);
    run_frame("abort", 0, 4, 4'hA, -1, -1, 8, -1, 14, -1, 2, 2, 1'b0);
    scen_basic("post_abort");

    // Asynchronous reset while a symbol is being presented.
    @(negedge clk);
    bus.frame_len        = 16'd1;
    bus.cfg_period       = 8'd0;
    bus.cfg_preamble_sym = 4'hA;
    bus.s_data           = 8'h3C;
    bus.s_valid          = 1'b1;
    bus.start            = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_dv", 32'(bus.sym_dv), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    scen_basic("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
